// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI front end.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    WAIT,
    SEND,
    DONE
  } state_e;

  localparam int PREAMBLE_BITS   = 1;
  localparam int RES_W           = 128;
  localparam int TIMEOUT_DEFAULT = 1024;

  // Serial frame length: one 128-bit block followed by an Nk-word key.
  function automatic int frame_bits(input int nk);
    return RES_W + nk * 32;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised MSB-first shift register: parallel load has priority over
// shift; shifting moves toward the MSB and inserts sin at bit 0.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] data_q, data_d;

  // Next value: load wins, otherwise optional shift-left.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {data_q[W-2:0], sin};
    end
  end

  // Storage with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q    = data_q;
  assign sout = data_q[W-1];

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI-side front end for an AES core: receives {data, key} MSB first,
// pulses core_start, waits for core_done, then returns a '1' preamble
// followed by the 128-bit result on SDO.
// Optional WAIT watchdog: define AES_SPI_TIMEOUT_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | CS high or frame not begun; SDO low
// RECV  | shifting frame bits in from SDI
// START | single cycle with core_start high; block/key presented
// WAIT  | waiting for core_done (or watchdog expiry)
// SEND  | preamble bit, then result MSB first
// DONE  | result sent; wait for CS to rise
module aes_spi_frontend
  import aes_spi_pkg::*;
#(
  parameter int Nk             = 4,
  parameter int Nr             = 10,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               CS,
  input  logic               SDI,
  output logic               SDO,
  output logic               core_start,
  output logic [RES_W-1:0]   core_data_in,
  output logic [Nk*32-1:0]   core_key,
  input  logic               core_done,
  input  logic [RES_W-1:0]   core_data_out,
  output logic               busy,
  output logic               err
);

  localparam int FRAME_BITS = frame_bits(Nk);
  localparam int KEY_W      = Nk * 32;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int SEND_LAST  = PREAMBLE_BITS + RES_W - 1;

  // Round count belongs to the attached core; carried here so both share one parameter set.
  localparam int nr_unused = Nr;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sdo_q, sdo_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic                rx_shift;
  logic                tx_load, tx_shift;
  logic [RES_W-1:0]    tx_load_val;
  logic                tx_sout;
  logic                tmr_expired;

  logic [FRAME_BITS-1:0] rx_q;
  logic                  rx_sout_unused;
  logic [RES_W-1:0]      tx_q_unused;

  spi_shift_reg #(.W(FRAME_BITS)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (rx_shift),
    .sin      (SDI),
    .q        (rx_q),
    .sout     (rx_sout_unused)
  );

  spi_shift_reg #(.W(RES_W)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (tx_load_val),
    .shift    (tx_shift),
    .sin      (1'b0),
    .q        (tx_q_unused),
    .sout     (tx_sout)
  );

`ifdef AES_SPI_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  assign tmr_expired = (tmr_q == '0);

  // Watchdog reloads during START and counts down through WAIT; err is sticky until the next frame begins.
  always_comb begin
    tmr_d = tmr_q;
    err_d = err_q;
    if (state_q == START) begin
      tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == WAIT && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
    if (state_q == IDLE && !CS) begin
      err_d = 1'b0;
    end else if (state_q == WAIT && !CS && !core_done && tmr_expired) begin
      err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;

  assign tmr_expired = 1'b0;
  assign err         = 1'b0;
`endif

  // Sequencing: next state, bit counter, shift controls and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sdo_d       = 1'b0;
    start_d     = 1'b0;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    tx_load_val = core_data_out;
    unique case (state_q)
      IDLE: begin
        if (!CS) begin
          rx_shift = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = RECV;
        end
      end
      RECV: begin
        if (CS) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rx_shift = 1'b1;
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            cnt_d   = '0;
            start_d = 1'b1;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = CS ? IDLE : WAIT;
      end
      WAIT: begin
        if (CS) begin
          state_d = IDLE;
        end else if (core_done || tmr_expired) begin
          // A timed-out WAIT still sends the preamble, then an all-zero result.
          tx_load     = 1'b1;
          tx_load_val = core_done ? core_data_out : '0;
          sdo_d       = 1'b1;
          cnt_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (CS) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(SEND_LAST)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          sdo_d    = tx_sout;
          tx_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (CS) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign SDO          = sdo_q;
  assign core_start   = start_q;
  assign busy         = busy_q;
  assign core_data_in = rx_q[FRAME_BITS-1 -: RES_W];
  assign core_key     = rx_q[KEY_W-1:0];

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Bench for aes_spi_frontend: a transaction-level model turns each frame
// (data, key, core latency, result) into the per-cycle output timeline the
// front end must produce; one negedge process compares the DUT to it.
module tb_aes_spi_frontend;

  localparam int NK  = 4;
  localparam int KW  = NK * 32;
  localparam int FB  = 128 + KW;
  localparam int TMO = 16;
`ifdef AES_SPI_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           CS;
  logic           SDI;
  logic           SDO;
  logic           core_start;
  logic [127:0]   core_data_in;
  logic [KW-1:0]  core_key;
  logic           core_done;
  logic [127:0]   core_data_out;
  logic           busy;
  logic           err;

  aes_spi_frontend #(.Nk(NK), .Nr(10), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .CS            (CS),
    .SDI           (SDI),
    .SDO           (SDO),
    .core_start    (core_start),
    .core_data_in  (core_data_in),
    .core_key      (core_key),
    .core_done     (core_done),
    .core_data_out (core_data_out),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic          chk_en = 1'b0;
  logic          exp_sdo, exp_start, exp_busy;
  logic          m_err, dk_en, cap_en;
  logic [127:0]  exp_d, cap;
  logic [KW-1:0] exp_k;

  task automatic chk_b(input string nm, input logic a, input logic e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
  endtask

  task automatic chk_v(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
  endtask

  // Single compare process against the model's expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_b("sdo", SDO, exp_sdo);
      chk_b("core_start", core_start, exp_start);
      chk_b("busy", busy, exp_busy);
      chk_b("err", err, m_err);
      if (dk_en) begin
        chk_v("core_data_in", core_data_in, exp_d);
        chk_v("core_key", core_key, exp_k);
      end
    end
    if (cap_en) cap = {cap[126:0], SDO};
  end

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic stray();
    return ($urandom_range(0, 7) == 0);
  endfunction

  // One clock: set the expected outputs for the cycle just begun and drive
  // the inputs that the next rising edge will sample.
  task automatic step(input logic e_sdo, input logic e_start, input logic e_busy,
                      input logic cs, input logic sdi, input logic done,
                      input logic [127:0] dout);
    @(posedge clk);
    #1;
    exp_sdo       = e_sdo;
    exp_start     = e_start;
    exp_busy      = e_busy;
    CS            = cs;
    SDI           = sdi;
    core_done     = done;
    core_data_out = dout;
  endtask

  // One transaction from IDLE. lat = WAIT cycles before the core answers.
  // rx_abort: raise CS instead of sending that bit index; wait_abort: raise
  // CS in that WAIT cycle (with core_done too if abort_done); send_rst: pull
  // rst low while result bit send_rst is on SDO. -1 disables each.
  task automatic frame(input logic [127:0] d, input logic [KW-1:0] k, input int lat,
                       input logic [127:0] res, input int rx_abort, input int wait_abort,
                       input logic abort_done, input int send_rst);
    logic [FB-1:0] bits;
    logic          tmo;
    int            nwait;
    int            nd;
    logic [127:0]  exp_res;
    bits = {d, k};
    step(1'b0, 1'b0, 1'b0, 1'b0, bits[FB-1], stray(), r128());
    for (int i = 1; i < FB; i++) begin
      if (i == rx_abort) begin
        step(1'b0, 1'b0, 1'b1, 1'b1, rb(), stray(), r128());
        step(1'b0, 1'b0, 1'b0, 1'b1, rb(), stray(), r128());
        step(1'b0, 1'b0, 1'b0, 1'b1, rb(), 1'b1, r128());
        step(1'b0, 1'b0, 1'b0, 1'b1, rb(), stray(), r128());
        return;
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, bits[FB-1-i], stray(), r128());
      if (i == 1) begin
        m_err = 1'b0;
        dk_en = 1'b0;
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, rb(), stray(), r128());
    exp_d = d;
    exp_k = k;
    dk_en = 1'b1;
    tmo     = TMO_EN && (lat > TMO);
    nwait   = tmo ? TMO : lat;
    exp_res = tmo ? 128'h0 : res;
    for (int w = 0; w < nwait; w++) begin
      if (w == wait_abort) begin
        step(1'b0, 1'b0, 1'b1, 1'b1, rb(), abort_done, r128());
        step(1'b0, 1'b0, 1'b0, 1'b1, rb(), 1'b0, r128());
        for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 1'b0, 1'b1, rb(), (j == 4), r128());
        return;
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, rb(), (!tmo && w == nwait - 1),
           (w == nwait - 1) ? res : r128());
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, rb(), stray(), r128());
    if (tmo) m_err = 1'b1;
    for (int i = 0; i < 128; i++) begin
      step(exp_res[127-i], 1'b0, 1'b1, 1'b0, rb(), stray(), r128());
      if (i == 0) cap_en = 1'b1;
      if (i == send_rst) begin
        #2;
        rst    = 1'b0;
        CS     = 1'b1;
        chk_en = 1'b0;
        cap_en = 1'b0;
        #1;
        chk_b("rst_sdo", SDO, 1'b0);
        chk_b("rst_core_start", core_start, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_err", err, 1'b0);
        chk_v("rst_core_data_in", core_data_in, 128'h0);
        chk_v("rst_core_key", core_key, 128'h0);
        m_err = 1'b0;
        dk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, rb(), stray(), r128());
        chk_en = 1'b1;
        return;
      end
    end
    nd = $urandom_range(1, 3);
    for (int j = 0; j < nd; j++) begin
      step(1'b0, 1'b0, 1'b1, (j == nd - 1), rb(), stray(), r128());
      if (j == 0) cap_en = 1'b0;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, rb(), stray(), r128());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, r, a5;
    rst           = 1'b0;
    CS            = 1'b1;
    SDI           = 1'b0;
    core_done     = 1'b0;
    core_data_out = 128'h0;
    m_err         = 1'b0;
    dk_en         = 1'b0;
    cap_en        = 1'b0;
    cap           = 128'h0;
    exp_sdo       = 1'b0;
    exp_start     = 1'b0;
    exp_busy      = 1'b0;
    a5            = {16{8'ha5}};

    #3;
    chk_b("reset_sdo", SDO, 1'b0);
    chk_b("reset_core_start", core_start, 1'b0);
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_err", err, 1'b0);
    chk_v("reset_core_data_in", core_data_in, 128'h0);
    chk_v("reset_core_key", core_key, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, r128());
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, r128());

    // FIPS-197 AES-128 known answer
    frame(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
          11, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, -1, 1'b0, -1);
    chk_v("fips_sdo_stream", cap, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // 37-cycle core latency returning a5 pattern
    frame(r128(), r128(), 37, a5, -1, -1, 1'b0, -1);
    chk_v("a5_sdo_stream", cap, TMO_EN ? 128'h0 : a5);

    // abort after 100 bits, then all-ones echo
    frame(r128(), r128(), 5, r128(), 100, -1, 1'b0, -1);
    frame({128{1'b1}}, {KW{1'b1}}, 3, {128{1'b1}}, -1, -1, 1'b0, -1);
    chk_v("echo_ones_stream", cap, {128{1'b1}});

    // abort in WAIT, late done ignored; abort coinciding with done
    frame(r128(), r128(), 10, r128(), -1, 2, 1'b0, -1);
    frame(r128(), r128(), 6, r128(), -1, 5, 1'b1, -1);

    // reset during SEND at result bit 60
    frame(r128(), r128(), 4, r128(), -1, -1, 1'b0, 60);

    // latency boundaries
    frame(r128(), r128(), 1, r128(), -1, -1, 1'b0, -1);
    frame(r128(), r128(), TMO, r128(), -1, -1, 1'b0, -1);

    // random echo-style transactions
    for (int n = 0; n < 5; n++) begin
      d = r128();
      r = d ^ r128();
      frame(d, r128(), $urandom_range(1, 40), r, -1, -1, 1'b0, -1);
    end

    // core that answers very late (watchdog territory when enabled)
    frame(r128(), r128(), 200, r128(), -1, -1, 1'b0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
